keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 180 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-multiplexed scan, lowest-column key wins,
// full-scan debounce of press and release, one-cycle strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  output logic [3:0] kpc,
  input  logic [3:0] kpr,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  logic [3:0]    rows_meta;
  logic [3:0]    rows;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    col;

  logic          hit;
  logic [1:0]    hit_row;
  logic          acc_found;
  logic [3:0]    acc_code;
  logic          prior_found;
  logic          cand_found;
  logic [3:0]    cand_code;
  logic          scan_done;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic [3:0]    code_next;
  logic          valid_next;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta <= '1;
      rows      <= '1;
    end else begin
      rows_meta <= kpr;
      rows      <= rows_meta;
    end
  end

  assign tick = (div == DIV_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      col <= '0;
    end else if (tick) begin
      div <= '0;
      col <= col + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign kpc = ~(4'b0001 << col);

  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!hit && !rows[r]) begin
        hit     = 1'b1;
        hit_row = 2'(r);
      end
    end
  end

  // The accumulator carries the earliest-column hit across a scan; column 0 starts it afresh.
  assign prior_found = acc_found && (col != 2'd0);
  assign cand_found  = prior_found || hit;
  assign cand_code   = prior_found ? acc_code : {hit_row, col};
  assign scan_done   = tick && (col == 2'd3);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      acc_found <= 1'b0;
      acc_code  <= '0;
    end else if (tick) begin
      acc_found <= cand_found;
      acc_code  <= cand_code;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      key_code  <= code_next;
      key_valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = key_code;
    valid_next = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (cand_found) begin
            code_next = cand_code;
            cnt_next  = 4'd1;
            if (DEB_N == 4'd1) begin
              state_next = PRESSED;
              valid_next = 1'b1;
            end else begin
              state_next = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (!cand_found) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cand_code == key_code) begin
            cnt_next = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_N) begin
              state_next = PRESSED;
              valid_next = 1'b1;
            end
          end else begin
            code_next = cand_code;
            cnt_next  = 4'd1;
          end
        end
        PRESSED: begin
          if (!cand_found || cand_code != key_code) begin
            if (DEB_N == 4'd1) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              state_next = DEB_RELEASE;
              cnt_next   = 4'd1;
            end
          end
        end
        DEB_RELEASE: begin
          if (cand_found && cand_code == key_code) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_N) begin
              state_next = IDLE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign key_held = (state == PRESSED) || (state == DEB_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scan table and
// randomized scans checked cycle by cycle against a per-scan debounce model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  typedef struct {
    logic [15:0] mask;
    bit          strobe;
    logic [3:0]  code;
    bit          held;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  kpc;
  logic [3:0]  kpr;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int          vectors = 0;
  int          errors  = 0;
  logic [3:0]  prev_code;
  bit          prev_held;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .CLOCK_50  (clk),
    .reset_n   (rst_n),
    .kpc       (kpc),
    .kpr       (kpr),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // A pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kpr = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kpc[c]) kpr[r] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " kpc"}, kpc, 4'b1110);
    check({tag, " key_code"}, key_code, 4'd0);
    check({tag, " key_valid"}, 4'(key_valid), 4'd0);
    check({tag, " key_held"}, 4'(key_held), 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n     = 1'b1;
    prev_code = '0;
    prev_held = 1'b0;
  endtask

  // One full scan starting right after a scan boundary; new values appear on its last edge.
  task automatic run_scan(input logic [15:0] mask, input bit strobe, input logic [3:0] code, input bit held);
    bit         last;
    logic [3:0] ek;
    keys = mask;
    for (int k = 1; k <= SCAN_CYC; k++) begin
      @(negedge clk);
      last = (k == SCAN_CYC);
      ek   = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("kpc", kpc, ek);
      check("key_valid", 4'(key_valid), 4'(last && strobe));
      check("key_code", key_code, last ? code : prev_code);
      check("key_held", 4'(key_held), 4'(last ? held : prev_held));
    end
    prev_code = code;
    prev_held = held;
  endtask

  task automatic add(input logic [15:0] m, input bit s, input int c, input bit h);
    vec_t v;
    v.mask = m; v.strobe = s; v.code = 4'(c); v.held = h;
    tbl.push_back(v);
  endtask

  // Key scanned first: lowest column, then lowest row within it.
  function automatic int candidate(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4+c]) return r*4 + c;
    return -1;
  endfunction

  initial begin
    logic [15:0] one;
    logic [15:0] mask;
    logic [15:0] dual;
    logic [15:0] samecol;
    int          cand, m_code, m_run, m_rel;
    bit          m_held, strobe;

    one     = 16'h0001;
    dual    = (one << 9) | (one << 3);
    samecol = (one << 6) | (one << 14);
    rst_n   = 1'b0;
    keys    = '0;

    repeat (10) add('0, 0, 0, 0);
    add(one << 6, 0, 6, 0); add(one << 6, 1, 6, 1);
    add(one << 6, 0, 6, 1); add(one << 6, 0, 6, 1);
    add('0, 0, 6, 1); add('0, 0, 6, 0); add('0, 0, 6, 0);
    add(one << 3, 0, 3, 0); add('0, 0, 3, 0); add('0, 0, 3, 0);
    add(dual, 0, 9, 0); add(dual, 1, 9, 1); add(dual, 0, 9, 1);
    add('0, 0, 9, 1); add(dual, 0, 9, 1); add(dual, 0, 9, 1);
    add('0, 0, 9, 1); add('0, 0, 9, 0);
    add(one << 5, 0, 5, 0); add(one, 0, 0, 0); add(one, 1, 0, 1);
    add(one << 15, 0, 0, 1); add(one << 15, 0, 0, 0);
    add(one << 15, 0, 15, 0); add(one << 15, 1, 15, 1);
    add('0, 0, 15, 1); add('0, 0, 15, 0);
    add(samecol, 0, 6, 0); add(samecol, 1, 6, 1); add('0, 0, 6, 1); add('0, 0, 6, 0);

    do_reset();
    foreach (tbl[i]) run_scan(tbl[i].mask, tbl[i].strobe, tbl[i].code, tbl[i].held);

    // Reset in the middle of a press debounce, key kept down throughout.
    run_scan(one << 6, 0, 6, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset held");
    rst_n     = 1'b1;
    prev_code = '0;
    prev_held = 1'b0;
    run_scan(one << 6, 0, 6, 0);
    run_scan(one << 6, 1, 6, 1);
    run_scan(one << 6, 0, 6, 1);
    run_scan('0, 0, 6, 1);
    run_scan('0, 0, 6, 0);

    do_reset();
    m_code = 0; m_run = 0; m_rel = 0; m_held = 0;
    mask   = '0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ;
        5, 6:          mask = '0;
        7, 8:          mask = one << $urandom_range(0, 15);
        default:       mask = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
      endcase
      cand   = candidate(mask);
      strobe = 0;
      if (!m_held) begin
        if (cand < 0) m_run = 0;
        else if (m_run > 0 && cand == m_code) m_run++;
        else begin
          m_code = cand;
          m_run  = 1;
        end
        if (m_run == DEB) begin
          strobe = 1;
          m_held = 1;
          m_run  = 0;
          m_rel  = 0;
        end
      end else begin
        if (cand == m_code) m_rel = 0;
        else m_rel++;
        if (m_rel == DEB) begin
          m_held = 0;
          m_rel  = 0;
          m_run  = 0;
        end
      end
      run_scan(mask, strobe, 4'(m_code), m_held);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
